// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if
//   Bundles the sram_* read and write channels between the bus matrix
//   (master) and the on-chip SRAM responder (slave).
//   Read  : arvalid/arready/raddr, rvalid/rready/rresp/rdata
//   Write : awvalid/awready/waddr, wvalid/wready/strob/wdata,
//           bvalid/bready/bresp
interface axi_sram_slave_if #(
  parameter int DATA_LEN  = 32,
  parameter int ADDR_LEN  = 32,
  parameter int STROB_LEN = 4
);
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_LEN-1:0]  raddr;
  logic                 rvalid;
  logic                 rready;
  logic [2:0]           rresp;
  logic [DATA_LEN-1:0]  rdata;
  logic                 awvalid;
  logic                 awready;
  logic [ADDR_LEN-1:0]  waddr;
  logic                 wvalid;
  logic                 wready;
  logic [STROB_LEN-1:0] strob;
  logic [DATA_LEN-1:0]  wdata;
  logic                 bvalid;
  logic                 bready;
  logic [2:0]           bresp;

  modport master (
    output arvalid, raddr, rready, awvalid, waddr, wvalid, strob, wdata, bready,
    input  arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, raddr, rready, awvalid, waddr, wvalid, strob, wdata, bready,
    output arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   Word-organised on-chip SRAM answering the sram_* channels. One read and
//   one write transaction are served at a time, independently, each with a
//   fixed programmable latency so requesters see multi-cycle responses.
//   Ports:
//     clk   - clock, all logic on the rising edge
//     rst_n - asynchronous active-low reset (memory contents are kept)
//     bus   - axi_sram_slave_if.slave, read and write channels
module axi_sram_slave #(
  parameter int DATA_LEN  = 32,
  parameter int ADDR_LEN  = 32,
  parameter int STROB_LEN = 4,
  parameter int MEM_DEPTH = 1024,
  parameter int READ_LAT  = 1,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_sram_slave_if.slave   bus
);
  localparam int OFF_W = $clog2(STROB_LEN);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = 16;
  localparam logic [ADDR_LEN:0] ADDR_LIMIT = (ADDR_LEN+1)'(MEM_DEPTH * STROB_LEN);
  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
    return {1'b0, a} < ADDR_LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_LEN-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  // ---------------- memory: one byte-wide array per strobe lane ----------
  logic [DATA_LEN-1:0]  rd_word;
  logic [IDX_W-1:0]     rd_idx;
  logic                 commit_en;
  logic [IDX_W-1:0]     commit_idx;
  logic [DATA_LEN-1:0]  cur_wdata;
  logic [STROB_LEN-1:0] cur_strob;

  for (genvar gi = 0; gi < STROB_LEN; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_DEPTH];
    always_ff @(posedge clk) begin
      if (commit_en && cur_strob[gi])
        lane_mem[commit_idx] <= cur_wdata[8*gi +: 8];
    end
    assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
  end

  // ---------------- read channel ----------------------------------------
  rd_state_t            rd_state_reg;
  logic [ADDR_LEN-1:0]  raddr_reg;
  logic [CNT_W-1:0]     rd_cnt_reg;
  logic                 arready_reg, rvalid_reg;
  logic [2:0]           rresp_reg;
  logic [DATA_LEN-1:0]  rdata_reg;
  logic [ADDR_LEN-1:0]  rd_addr;
  logic [DATA_LEN-1:0]  rd_data_s;
  logic [2:0]           rd_resp_s;

  // In idle the address comes straight off the bus so READ_LAT=1 can sample
  // on the handshake edge; afterwards the latched copy is used.
  always_comb begin
    rd_addr   = (rd_state_reg == R_IDLE) ? bus.raddr : raddr_reg;
    rd_data_s = in_range(rd_addr) ? rd_word : '0;
    rd_resp_s = in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
  end
  assign rd_idx = word_idx(rd_addr);

  // The counter is loaded with READ_LAT-1 and the transition fires on the
  // edge where it would reach zero, so rvalid rises READ_LAT edges after AR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= R_IDLE;
      raddr_reg    <= '0;
      rd_cnt_reg   <= '0;
      arready_reg  <= 1'b1;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (bus.arvalid) begin
            raddr_reg   <= bus.raddr;
            arready_reg <= 1'b0;
            rd_cnt_reg  <= CNT_W'(READ_LAT - 1);
            if (READ_LAT == 1) begin
              rd_state_reg <= R_RESP;
              rvalid_reg   <= 1'b1;
              rdata_reg    <= rd_data_s;
              rresp_reg    <= rd_resp_s;
            end else begin
              rd_state_reg <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt_reg == CNT_W'(1)) begin
            rd_state_reg <= R_RESP;
            rvalid_reg   <= 1'b1;
            rdata_reg    <= rd_data_s;
            rresp_reg    <= rd_resp_s;
          end
          rd_cnt_reg <= rd_cnt_reg - CNT_W'(1);
        end
        R_RESP: begin
          if (bus.rready) begin
            rd_state_reg <= R_IDLE;
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ---------------------------------------
  wr_state_t            wr_state_reg;
  logic [ADDR_LEN-1:0]  waddr_reg;
  logic [DATA_LEN-1:0]  wdata_reg;
  logic [STROB_LEN-1:0] strob_reg;
  logic                 aw_got_reg, w_got_reg;
  logic                 awready_reg, wready_reg, bvalid_reg;
  logic [2:0]           bresp_reg;
  logic [CNT_W-1:0]     wr_cnt_reg;
  logic                 aw_hs, w_hs, both_ready, commit_go;
  logic [ADDR_LEN-1:0]  cur_waddr;

  // cur_* select a beat accepted this cycle over the latched copy, so AW/W
  // arriving on the committing edge (WRITE_LAT=1) still reach memory.
  always_comb begin
    aw_hs      = (wr_state_reg == W_IDLE) && awready_reg && bus.awvalid;
    w_hs       = (wr_state_reg == W_IDLE) && wready_reg && bus.wvalid;
    both_ready = (wr_state_reg == W_IDLE) && (aw_got_reg || aw_hs) && (w_got_reg || w_hs);
    cur_waddr  = aw_hs ? bus.waddr : waddr_reg;
    cur_wdata  = w_hs ? bus.wdata : wdata_reg;
    cur_strob  = w_hs ? bus.strob : strob_reg;
    commit_go  = (WRITE_LAT == 1) ? both_ready
                                  : ((wr_state_reg == W_WAIT) && (wr_cnt_reg == CNT_W'(1)));
    // rst_n gating keeps the memory untouched while reset is held.
    commit_en  = commit_go && in_range(cur_waddr) && rst_n;
  end
  assign commit_idx = word_idx(cur_waddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_reg <= W_IDLE;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      strob_reg    <= '0;
      aw_got_reg   <= 1'b0;
      w_got_reg    <= 1'b0;
      awready_reg  <= 1'b1;
      wready_reg   <= 1'b1;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      wr_cnt_reg   <= '0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            waddr_reg   <= bus.waddr;
            aw_got_reg  <= 1'b1;
            awready_reg <= 1'b0;
          end
          if (w_hs) begin
            wdata_reg  <= bus.wdata;
            strob_reg  <= bus.strob;
            w_got_reg  <= 1'b1;
            wready_reg <= 1'b0;
          end
          if (both_ready) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            wr_cnt_reg <= CNT_W'(WRITE_LAT - 1);
            if (WRITE_LAT == 1) begin
              wr_state_reg <= W_RESP;
              bvalid_reg   <= 1'b1;
              bresp_reg    <= in_range(cur_waddr) ? RESP_OKAY : RESP_SLVERR;
            end else begin
              wr_state_reg <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (wr_cnt_reg == CNT_W'(1)) begin
            wr_state_reg <= W_RESP;
            bvalid_reg   <= 1'b1;
            bresp_reg    <= in_range(waddr_reg) ? RESP_OKAY : RESP_SLVERR;
          end
          wr_cnt_reg <= wr_cnt_reg - CNT_W'(1);
        end
        W_RESP: begin
          if (bus.bready) begin
            wr_state_reg <= W_IDLE;
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  assign bus.arready = arready_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.awready = awready_reg;
  assign bus.wready  = wready_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Two responders side by side: index 0 with READ_LAT=1/WRITE_LAT=1 and
//   index 1 with READ_LAT=4/WRITE_LAT=3. A byte-lane memory model per
//   instance predicts read data and responses.
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic [31:0] raddr_d [2];
  logic [31:0] waddr_d [2];
  logic [31:0] wdata_d [2];
  logic [3:0]  strob_d [2];
  logic [1:0]  arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [2:0]  rresp_o [2];
  logic [2:0]  bresp_o [2];
  logic [31:0] rdata_o [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    axi_sram_slave_if #(.DATA_LEN(32), .ADDR_LEN(32), .STROB_LEN(4)) bus ();
    axi_sram_slave #(
      .DATA_LEN(32), .ADDR_LEN(32), .STROB_LEN(4), .MEM_DEPTH(1024),
      .READ_LAT(gi == 0 ? 1 : 4), .WRITE_LAT(gi == 0 ? 1 : 3)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    assign bus.arvalid = arvalid_d[gi];
    assign bus.raddr   = raddr_d[gi];
    assign bus.rready  = rready_d[gi];
    assign bus.awvalid = awvalid_d[gi];
    assign bus.waddr   = waddr_d[gi];
    assign bus.wvalid  = wvalid_d[gi];
    assign bus.strob   = strob_d[gi];
    assign bus.wdata   = wdata_d[gi];
    assign bus.bready  = bready_d[gi];
    assign arready_o[gi] = bus.arready;
    assign rvalid_o[gi]  = bus.rvalid;
    assign rresp_o[gi]   = bus.rresp;
    assign rdata_o[gi]   = bus.rdata;
    assign awready_o[gi] = bus.awready;
    assign wready_o[gi]  = bus.wready;
    assign bvalid_o[gi]  = bus.bvalid;
    assign bresp_o[gi]   = bus.bresp;
  end

  logic [31:0] model_mem [2][1024];
  int checks = 0;
  int failures = 0;

  function automatic int rlat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int wlat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // 1024 words x 4 bytes
  function automatic logic in_rng(input logic [31:0] a);
    return a < 32'h1000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    for (int d = 0; d < 2; d++) begin
      check_val("rst_arready", 32'(arready_o[d]), 1);
      check_val("rst_awready", 32'(awready_o[d]), 1);
      check_val("rst_wready",  32'(wready_o[d]), 1);
      check_val("rst_rvalid",  32'(rvalid_o[d]), 0);
      check_val("rst_bvalid",  32'(bvalid_o[d]), 0);
      check_val("rst_rresp",   32'(rresp_o[d]), 0);
      check_val("rst_bresp",   32'(bresp_o[d]), 0);
      check_val("rst_rdata",   rdata_o[d], 0);
    end
  endtask

  task automatic do_read(input int d, input logic [31:0] addr, input int hold);
    int n;
    int lat;
    logic [31:0] exp_d;
    logic [2:0]  exp_r;
    exp_d = in_rng(addr) ? model_mem[d][addr[11:2]] : 32'h0;
    exp_r = in_rng(addr) ? 3'b000 : 3'b010;
    raddr_d[d] = addr;
    arvalid_d[d] = 1'b1;
    n = 0;
    while (!arready_o[d] && n < 50) begin @(posedge clk); #1; n++; end
    check_val("arready_idle", 32'(arready_o[d]), 1);
    @(posedge clk); #1;
    arvalid_d[d] = 1'b0;
    lat = 1;
    while (!rvalid_o[d] && lat < 40) begin
      check_val("arready_busy", 32'(arready_o[d]), 0);
      @(posedge clk); #1;
      lat++;
    end
    check_val("rd_latency", 32'(lat), 32'(rlat(d)));
    check_val("rdata", rdata_o[d], exp_d);
    check_val("rresp", 32'(rresp_o[d]), 32'(exp_r));
    check_val("arready_resp", 32'(arready_o[d]), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("rvalid_hold", 32'(rvalid_o[d]), 1);
      check_val("rdata_hold", rdata_o[d], exp_d);
    end
    rready_d[d] = 1'b1;
    @(posedge clk); #1;
    rready_d[d] = 1'b0;
    check_val("rvalid_drop", 32'(rvalid_o[d]), 0);
    check_val("arready_back", 32'(arready_o[d]), 1);
    $display("RD dut%0d addr=%08h data=%08h resp=%0d lat=%0d", d, addr, exp_d, exp_r, lat);
  endtask

  // wdelay/awdelay: cycle offsets at which W and AW are first presented.
  // abort: return right after both beats are accepted (no model commit).
  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int wdelay, input int awdelay,
                          input int bhold, input bit abort);
    int t;
    int lat;
    bit aw_done, w_done, aw_now, w_now;
    logic [2:0] exp_b;
    exp_b = in_rng(addr) ? 3'b000 : 3'b010;
    waddr_d[d] = addr;
    wdata_d[d] = data;
    strob_d[d] = strb;
    aw_done = 1'b0;
    w_done = 1'b0;
    t = 0;
    while (!(aw_done && w_done) && t < 60) begin
      awvalid_d[d] = !aw_done && (t >= awdelay);
      wvalid_d[d]  = !w_done && (t >= wdelay);
      aw_now = awvalid_d[d] && awready_o[d];
      w_now  = wvalid_d[d] && wready_o[d];
      @(posedge clk); #1;
      if (aw_now) begin aw_done = 1'b1; awvalid_d[d] = 1'b0; end
      if (w_now)  begin w_done = 1'b1;  wvalid_d[d] = 1'b0; end
      if (aw_done) check_val("awready_low", 32'(awready_o[d]), 0);
      if (w_done)  check_val("wready_low", 32'(wready_o[d]), 0);
      t++;
    end
    awvalid_d[d] = 1'b0;
    wvalid_d[d] = 1'b0;
    check_val("wr_accept", 32'(aw_done && w_done), 1);
    if (abort) begin
      $display("WR dut%0d addr=%08h data=%08h strb=%h accepted, to be aborted", d, addr, data, strb);
      return;
    end
    if (in_rng(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[d][addr[11:2]][8*b +: 8] = data[8*b +: 8];
    lat = 1;
    while (!bvalid_o[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    check_val("wr_latency", 32'(lat), 32'(wlat(d)));
    check_val("bresp", 32'(bresp_o[d]), 32'(exp_b));
    for (int i = 0; i < bhold; i++) begin
      @(posedge clk); #1;
      check_val("bvalid_hold", 32'(bvalid_o[d]), 1);
      check_val("bresp_hold", 32'(bresp_o[d]), 32'(exp_b));
      check_val("wready_hold", 32'(wready_o[d]), 0);
    end
    bready_d[d] = 1'b1;
    @(posedge clk); #1;
    bready_d[d] = 1'b0;
    check_val("bvalid_drop", 32'(bvalid_o[d]), 0);
    check_val("awready_back", 32'(awready_o[d]), 1);
    check_val("wready_back", 32'(wready_o[d]), 1);
    $display("WR dut%0d addr=%08h data=%08h strb=%h resp=%0d lat=%0d", d, addr, data, strb, exp_b, lat);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arvalid_d = '0; rready_d = '0; awvalid_d = '0; wvalid_d = '0; bready_d = '0;
    for (int d = 0; d < 2; d++) begin
      raddr_d[d] = '0; waddr_d[d] = '0; wdata_d[d] = '0; strob_d[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // give the first 16 words defined contents
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        do_write(d, 32'(w * 4), $urandom, 4'hF, 0, 0, 0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      do_write(d, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
      do_read(d, 32'h10, 0);
      do_write(d, 32'h10, 32'h11223344, 4'b0101, 0, 0, 0, 1'b0);
      do_read(d, 32'h10, 0);
      check_val("partial_rdata", rdata_o[d], 32'hDE22BE44);
      do_write(d, 32'h14, $urandom, 4'hF, 0, 3, 4, 1'b0);
      do_read(d, 32'h14, 2);
      do_write(d, 32'h18, $urandom, 4'h0, 2, 0, 1, 1'b0);
      do_read(d, 32'h18, 0);
      do_read(d, 32'h1000, 1);
      do_write(d, 32'h1000, $urandom, 4'hF, 0, 0, 0, 1'b0);
      do_read(d, 32'h0, 0);
    end

    // same-edge read sample and write commit: read sees pre-write data
    fork
      do_write(0, 32'h20, 32'hA5A55A5A, 4'hF, 0, 0, 0, 1'b0);
      do_read(0, 32'h20, 0);
    join
    do_read(0, 32'h20, 0);

    // reset while the slow instance is in its write wait state
    do_write(1, 32'h1C, 32'hCAFEF00D, 4'hF, 0, 0, 0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(1, 32'h1C, 0);

    for (int it = 0; it < 80; it++) begin
      int d;
      logic [31:0] addr;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      else addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_read(d, addr, int'($urandom_range(0, 3)));
      else
        do_write(d, addr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
